mem_arbiter: RTL
================

# mem_arbiter

- Shares the single-port program/data RAM between two requesters: the instruction-fetch path (PC unit) and the data load/store path (memory stage of the control unit).
- Serialises accesses, drives the RAM address, write-enable and write-data, and returns read data with a per-port valid pulse after a fixed RAM read latency.
- Sits between the requesters and `fake_ram`.

## Interface

Parameters:
- `DATA_W`, 16, data width.
- `ADDR_W`, 16, address width.
- `RD_LAT`, 1, RAM read latency in cycles. Legal range is 1..3; any other value must fail elaboration.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch request accepted (1-cycle pulse).
- `if_rvalid` out 1: fetch read data valid (1-cycle pulse).
- `if_rdata` out DATA_W: fetch read data.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: write data.
- `d_gnt` out 1: data request accepted (1-cycle pulse).
- `d_rvalid` out 1: data read data valid (1-cycle pulse).
- `d_rdata` out DATA_W: data read data.
- `ram_we` out 1: RAM write enable.
- `ram_addr` out ADDR_W: RAM address.
- `ram_wdata` out DATA_W: RAM write data.
- `ram_rdata` in DATA_W: RAM read data.
- `busy` out 1: high whenever state is not IDLE.

## Operation

- The FSM has two states, IDLE and ACCESS, plus a 2-bit latency counter `lat_cnt`.
- **IDLE:**
  - Sample `if_req` and `d_req`. If neither is set, stay in IDLE.
  - Otherwise select a winner and register `ram_addr`, `ram_wdata` and `ram_we` from it.
  - `ram_we` = `d_we` for a data winner, 0 for a fetch winner.
  - Pulse the winner's `gnt`, load `lat_cnt` = RD_LAT, and go to ACCESS.
- **ACCESS, write:** `ram_we` is high for exactly this one cycle. It clears on the next edge and the FSM returns to IDLE. No `rvalid` is produced.
- **ACCESS, read:**
  - `lat_cnt` decrements each edge.
  - On the edge where `lat_cnt` == 1: capture `ram_rdata` into the owning port's `rdata`, pulse that port's `rvalid`, and return to IDLE.
- **Arbitration, default:** fixed priority, data over fetch.
- **Requests outside IDLE:** `req` is ignored while in ACCESS. A requester holds `req`/`addr`/`wdata`/`we` stable until it samples its `gnt` high, then drops or changes them.
- **Held read data:** `if_rdata` and `d_rdata` hold their last captured value until that port's next `rvalid`. The other port's `rdata` is never disturbed.
- **Held RAM signals:** `ram_addr` and `ram_wdata` hold their last value in IDLE. `ram_we` is 0 whenever it is not in a write ACCESS cycle.
- **Reset values:** all outputs 0, state IDLE, `lat_cnt` 0, round-robin pointer = data, meaning fetch wins the first tie.
- **Reset asserted mid-access:** the access is aborted immediately and asynchronously.
  - `ram_we` is forced to 0.
  - No `rvalid` is produced for the aborted access.
  - `rdata` registers return to 0.

## Timing

- Request sampled in IDLE at edge N gives `gnt`, `ram_addr` and `ram_we` valid from edge N until edge N+1.
- Read: `rvalid`/`rdata` asserted from edge N+RD_LAT for one cycle.
- Write: complete at edge N+1.
- Earliest next grant:
  - after a read: edge N+RD_LAT+1, i.e. read throughput is 1 access per RD_LAT+1 cycles;
  - after a write: edge N+2.
- `gnt` and `rvalid` are registered; there is no combinational path from any input to any output.
- `busy` is high from edge N until the edge at which the FSM returns to IDLE.

## Configuration

- Macro: `MEM_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration.
  - A 1-bit last-granted pointer updates on every grant.
  - On a simultaneous request, the port not granted last wins.
  - A lone requester always wins.
- **Undefined:** fixed priority, data over fetch. The pointer logic is not compiled.

## Test plan

- **Reset behaviour:** hold `reset`=0 with both `req`=1 for 5 cycles → all outputs 0 and `busy`=0. Release `reset` → first grant occurs on the following edge.
- **Single fetch read, RD_LAT=1:** `if_addr`=0x0004, RAM model returns 0x1234 → `if_gnt` at edge N, `ram_addr`=0x0004 with `ram_we`=0, `if_rvalid`=1 with `if_rdata`=0x1234 at N+1. `d_rvalid` stays 0.
- **Write then read:** data write 0x0010 ← 0xBEEF → `d_gnt`, `ram_we` high exactly 1 cycle, no `d_rvalid`. Then a data read of 0x0010 → `d_rdata`=0xBEEF with `d_rvalid` pulse.
- **Fixed-priority tie, macro undefined:** `if_req` and `d_req` both rise at the same edge, addresses 0x0020 and 0x0030 → `d_gnt` at N, `if_gnt` at N+2. Read data returns at N+1 and N+3, each on the correct port.
- **Round-robin, macro defined:** both requests held continuously for 4 grants → grant order fetch, data, fetch, data. No port receives two consecutive grants.
- **Reset mid-access, RD_LAT=3:** assert `reset` one cycle after an `if_gnt` for a read → no `if_rvalid`, `ram_we`=0, `busy`=0, and `if_rdata`=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Requester-side and RAM-side signal bundle for mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);

   // Instruction-fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   // Data load/store port
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;

   // Single-port RAM side
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter view
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             ram_we, ram_addr, ram_wdata
   );

   // Requester / RAM-model view
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             ram_we, ram_addr, ram_wdata
   );

endinterface : mem_arbiter_if
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises fetch and data accesses onto one single-port RAM.
// Config   : define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration,
//            otherwise fixed priority with data over fetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   mem_arbiter_if.slave bus,
   output logic         busy
);

   generate
      if (RD_LAT < 1 || RD_LAT > 3) begin : g_rd_lat_illegal
         $error("mem_arbiter: RD_LAT must be in the range 1..3");
      end
   endgenerate

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   state_t            state_q,     state_d;
   logic [1:0]        lat_cnt_q,   lat_cnt_d;
   logic              own_data_q,  own_data_d;
   logic              wr_q,        wr_d;
   logic              if_gnt_q,    if_gnt_d;
   logic              d_gnt_q,     d_gnt_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              d_rvalid_q,  d_rvalid_d;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
   logic              ram_we_q,    ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   logic              grant;
   logic              pick_data;

   assign grant = (state_q == IDLE) && (bus.if_req || bus.d_req);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Pointer remembers who won last; it resets to "data" so fetch wins the first tie.
   logic last_data_q, last_data_d;

   always_comb begin
      pick_data = bus.d_req;
      if (bus.d_req && bus.if_req) begin
         pick_data = ~last_data_q;
      end
   end

   always_comb begin
      last_data_d = last_data_q;
      if (grant) begin
         last_data_d = pick_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_data_q <= 1'b1;
      end else begin
         last_data_q <= last_data_d;
      end
   end
`else
   assign pick_data = bus.d_req;
`endif

   always_comb begin
      state_d     = state_q;
      lat_cnt_d   = lat_cnt_q;
      own_data_d  = own_data_q;
      wr_d        = wr_q;
      if_gnt_d    = 1'b0;
      d_gnt_d     = 1'b0;
      if_rvalid_d = 1'b0;
      d_rvalid_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;

      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d    = ACCESS;
               lat_cnt_d  = LAT_INIT;
               own_data_d = pick_data;
               if (pick_data) begin
                  d_gnt_d     = 1'b1;
                  wr_d        = bus.d_we;
                  ram_we_d    = bus.d_we;
                  ram_addr_d  = bus.d_addr;
                  ram_wdata_d = bus.d_wdata;
               end else begin
                  if_gnt_d    = 1'b1;
                  wr_d        = 1'b0;
                  ram_addr_d  = bus.if_addr;
               end
            end
         end

         ACCESS: begin
            if (wr_q) begin
               state_d   = IDLE;
               lat_cnt_d = 2'd0;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
               // Last latency cycle: RAM output is valid now, hand it to the owner.
               if (lat_cnt_q == 2'd1) begin
                  state_d = IDLE;
                  if (own_data_q) begin
                     d_rvalid_d = 1'b1;
                     d_rdata_d  = bus.ram_rdata;
                  end else begin
                     if_rvalid_d = 1'b1;
                     if_rdata_d  = bus.ram_rdata;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         lat_cnt_q   <= 2'd0;
         own_data_q  <= 1'b0;
         wr_q        <= 1'b0;
         if_gnt_q    <= 1'b0;
         d_gnt_q     <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         lat_cnt_q   <= lat_cnt_d;
         own_data_q  <= own_data_d;
         wr_q        <= wr_d;
         if_gnt_q    <= if_gnt_d;
         d_gnt_q     <= d_gnt_d;
         if_rvalid_q <= if_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt_q;
   assign bus.if_rvalid = if_rvalid_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_gnt     = d_gnt_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign busy          = (state_q == ACCESS);

endmodule : mem_arbiter
`default_nettype wire
